obi_wrr_arbiter: RTL and testbench

OBI_WRR_ARBITER -- requirements
Module: obi_wrr_arbiter

---
 rtl/obi_wrr_arbiter_pkg.sv | 16 +
 rtl/fifo_v3.sv | 73 +++++++
 rtl/obi_wrr_arbiter.sv | 146 ++++++++++++++
 tb/tb_obi_wrr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_wrr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// obi_wrr_arbiter_pkg : shared helpers for the OBI weighted round-robin arbiter
// Revision: 1.0
// ============================================================================
package obi_wrr_arbiter_pkg;

  localparam int unsigned MinIdxWidth = 1;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : MinIdxWidth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// fifo_v3 : synchronous FIFO, port-compatible subset of the common_cells FIFO
// Revision: 1.0
// ============================================================================
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [ADDR_DEPTH-1:0]             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_DEPTH:0]               cnt_q, cnt_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_q, mem_d;
  logic                              do_push, do_pop;

  assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    data_o   = mem_q[rd_ptr_q];
    if (FALL_THROUGH && (cnt_q == '0)) data_o = data_i;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    // Fall-through push+pop on an empty FIFO bypasses storage entirely.
    if (FALL_THROUGH && (cnt_q == '0) && do_push && do_pop) begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// obi_wrr_arbiter : weighted round-robin OBI handshake arbiter with ID FIFO
// Revision: 1.0
// ============================================================================
module obi_wrr_arbiter
  import obi_wrr_arbiter_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned NumMaxTrans   = 4,
  parameter int unsigned WeightWidth   = 4,
  parameter bit          StrayRspCheck = 1'b1,
  localparam int unsigned IdxWidth     = idx_width(NumReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_i,
  output logic [NumReq-1:0]                   gnt_o,
  input  logic [NumReq-1:0][WeightWidth-1:0]  weight_i,
  output logic [IdxWidth-1:0]                 sel_o,
  output logic                                mst_req_o,
  input  logic                                mst_gnt_i,
  input  logic                                mst_rvalid_i,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [IdxWidth-1:0]                 rsp_idx_o,
  output logic                                busy_o
);

  logic [IdxWidth-1:0]                 ptr_q, ptr_d, lock_idx_q, lock_idx_d;
  logic [WeightWidth-1:0]              cnt_q, cnt_d;
  logic                                lock_q, lock_d;
  logic [NumReq-1:0][WeightWidth-1:0]  eff_w;
  logic [IdxWidth-1:0]                 arb_idx, cand, sel_int, sel_nxt, fifo_head;
  logic [IdxWidth:0]                   sum;
  logic                                arb_valid, req_int, grant;
  logic                                fifo_full, fifo_empty;
  logic [WeightWidth:0]                cnt_inc;

  always_comb begin
    for (int k = 0; k < NumReq; k++) begin
      eff_w[k] = (weight_i[k] == '0) ? WeightWidth'(1) : weight_i[k];
    end
  end

  // Stay on ptr while it has budget, otherwise search cyclically from ptr+1.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    sum       = '0;
    cand      = '0;
    if (req_i[ptr_q] && (cnt_q < eff_w[ptr_q])) begin
      arb_valid = 1'b1;
      arb_idx   = ptr_q;
    end else begin
      for (int unsigned i = 1; i <= NumReq; i++) begin
        sum = {1'b0, ptr_q} + (IdxWidth+1)'(i);
        if (sum >= (IdxWidth+1)'(NumReq)) sum = sum - (IdxWidth+1)'(NumReq);
        cand = sum[IdxWidth-1:0];
        if (!arb_valid && req_i[cand]) begin
          arb_valid = 1'b1;
          arb_idx   = cand;
        end
      end
    end
  end

  assign sel_int   = lock_q ? lock_idx_q : arb_idx;
  assign req_int   = lock_q ? req_i[lock_idx_q] : arb_valid;
  assign mst_req_o = req_int & ~fifo_full & ~rst_i;
  assign sel_o     = rst_i ? '0 : sel_int;
  assign grant     = mst_req_o & mst_gnt_i;
  assign sel_nxt   = (sel_int == IdxWidth'(NumReq-1)) ? '0 : sel_int + 1'b1;
  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign busy_o    = ~fifo_empty & ~rst_i;
  assign rsp_idx_o = (fifo_empty | rst_i) ? '0 : fifo_head;

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      gnt_o[k]    = grant & (sel_int == IdxWidth'(k));
      rvalid_o[k] = mst_rvalid_i & ~fifo_empty & ~rst_i & (fifo_head == IdxWidth'(k));
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    lock_d     = mst_req_o & ~mst_gnt_i;
    lock_idx_d = sel_int;
    if (grant) begin
      if (sel_int == ptr_q) begin
        if (cnt_inc >= {1'b0, eff_w[sel_int]}) begin
          ptr_d = sel_nxt;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc[WeightWidth-1:0];
        end
      end else if (eff_w[sel_int] == WeightWidth'(1)) begin
        ptr_d = sel_nxt;
        cnt_d = '0;
      end else begin
        ptr_d = sel_int;
        cnt_d = WeightWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IdxWidth),
    .DEPTH        (NumMaxTrans)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (sel_int),
    .push_i  (grant),
    .data_o  (fifo_head),
    .pop_i   (mst_rvalid_i & ~fifo_empty)
  );

  a_stray_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
    !(StrayRspCheck && mst_rvalid_i && fifo_empty));

  a_rsp_with_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
    !(mst_rvalid_i && fifo_empty && grant));

endmodule
`default_nettype wire

// File: tb/tb_obi_wrr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_obi_wrr_arbiter : scoreboard bench for the weighted round-robin arbiter
// Revision: 1.0
// ============================================================================
module tb_obi_wrr_arbiter;

  logic            clk;
  logic            rst;
  logic [2:0]      req, gnt, rvalid;
  logic [2:0][3:0] weight;
  logic [1:0]      sel, rsp_idx;
  logic            mst_req, mst_gnt, mst_rvalid, busy;
  logic [2:0]      req_s, gnt_s, rvalid_s;
  logic [1:0]      sel_s, rsp_idx_s;
  logic            mst_req_s, mst_gnt_s, mst_rvalid_s, busy_s;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int exp_q[$];
  int out_q[$];

  obi_wrr_arbiter #(.NumReq(3), .NumMaxTrans(4), .WeightWidth(4), .StrayRspCheck(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .weight_i(weight), .sel_o(sel),
    .mst_req_o(mst_req), .mst_gnt_i(mst_gnt), .mst_rvalid_i(mst_rvalid),
    .rvalid_o(rvalid), .rsp_idx_o(rsp_idx), .busy_o(busy)
  );

  obi_wrr_arbiter #(.NumReq(3), .NumMaxTrans(2), .WeightWidth(4), .StrayRspCheck(1'b1)) u_dut_small (
    .clk_i(clk), .rst_i(rst), .req_i(req_s), .gnt_o(gnt_s), .weight_i(weight), .sel_o(sel_s),
    .mst_req_o(mst_req_s), .mst_gnt_i(mst_gnt_s), .mst_rvalid_i(mst_rvalid_s),
    .rvalid_o(rvalid_s), .rsp_idx_o(rsp_idx_s), .busy_o(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  // Leaves the bench 1 time unit after a rising edge with reset just released.
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; mst_gnt = 1'b0; mst_rvalid = 1'b0;
    req_s = '0; mst_gnt_s = 1'b0; mst_rvalid_s = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b111; mst_gnt = 1'b1; mst_rvalid = 1'b1;
    req_s = 3'b111; mst_gnt_s = 1'b1; mst_rvalid_s = 1'b0;
    weight = {4'd1, 4'd1, 4'd1};
    @(negedge clk);
    check_cnt++; if (gnt !== 3'b000) $display("FAIL reset_gnt: got %b want 000", gnt); else pass_cnt++;
    check_cnt++; if (mst_req !== 1'b0) $display("FAIL reset_mst_req: got %b want 0", mst_req); else pass_cnt++;
    check_cnt++; if (sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", sel); else pass_cnt++;
    check_cnt++; if (rvalid !== 3'b000) $display("FAIL reset_rvalid: got %b want 000", rvalid); else pass_cnt++;
    check_cnt++; if (rsp_idx !== 2'd0) $display("FAIL reset_rsp_idx: got %0d want 0", rsp_idx); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    check_cnt++; if (gnt_s !== 3'b000) $display("FAIL reset_gnt_small: got %b want 000", gnt_s); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_wrr_order(input string name, input logic [2:0][3:0] w, input int exp_seq [8]);
    int e, r;
    logic [2:0] oh;
    apply_reset();
    weight = w;
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_seq[i]);
    for (int c = 0; c < 8; c++) begin
      req = 3'b111; mst_gnt = 1'b1; mst_rvalid = (out_q.size() != 0);
      @(negedge clk);
      e = exp_q.pop_front();
      oh = 3'b001 << e;
      check_cnt++; if (gnt !== oh) $display("FAIL %s_gnt%0d: got %b want %b", name, c, gnt, oh); else pass_cnt++;
      if (mst_rvalid) begin
        r = out_q.pop_front();
        oh = 3'b001 << r;
        check_cnt++; if (rvalid !== oh) $display("FAIL %s_rvalid%0d: got %b want %b", name, c, rvalid, oh); else pass_cnt++;
      end
      out_q.push_back(e);
      @(posedge clk); #1;
    end
    req = '0; mst_gnt = 1'b0;
    for (int c = 0; c < 8 && out_q.size() != 0; c++) begin
      mst_rvalid = 1'b1;
      @(negedge clk);
      r = out_q.pop_front();
      oh = 3'b001 << r;
      check_cnt++; if (rvalid !== oh) $display("FAIL %s_drain_rvalid: got %b want %b", name, rvalid, oh); else pass_cnt++;
      check_cnt++; if (rsp_idx !== 2'(r)) $display("FAIL %s_drain_idx: got %0d want %0d", name, rsp_idx, r); else pass_cnt++;
      @(posedge clk); #1;
    end
    mst_rvalid = 1'b0;
    @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL %s_idle_busy: got %b want 0", name, busy); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_lock_hold();
    int e;
    logic [2:0] oh;
    apply_reset();
    weight = {4'd1, 4'd1, 4'd1};
    exp_q.push_back(1);
    exp_q.push_back(0);
    for (int c = 0; c < 5; c++) begin
      req = (c == 0) ? 3'b010 : 3'b011; mst_gnt = 1'b0;
      @(negedge clk);
      check_cnt++; if (sel !== 2'd1) $display("FAIL lock_sel%0d: got %0d want 1", c, sel); else pass_cnt++;
      check_cnt++; if (mst_req !== 1'b1) $display("FAIL lock_req%0d: got %b want 1", c, mst_req); else pass_cnt++;
      check_cnt++; if (gnt !== 3'b000) $display("FAIL lock_gnt%0d: got %b want 000", c, gnt); else pass_cnt++;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 2; c++) begin
      req = 3'b011; mst_gnt = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      oh = 3'b001 << e;
      check_cnt++; if (gnt !== oh) $display("FAIL lock_release_gnt%0d: got %b want %b", c, gnt, oh); else pass_cnt++;
      out_q.push_back(e);
      @(posedge clk); #1;
    end
    req = '0; mst_gnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mst_rvalid = 1'b1;
      @(negedge clk);
      e = out_q.pop_front();
      oh = 3'b001 << e;
      check_cnt++; if (rvalid !== oh) $display("FAIL lock_rvalid%0d: got %b want %b", c, rvalid, oh); else pass_cnt++;
      @(posedge clk); #1;
    end
    mst_rvalid = 1'b0;
  endtask

  task automatic test_fifo_full();
    int e;
    logic [2:0] oh;
    apply_reset();
    weight = {4'd1, 4'd1, 4'd1};
    req_s = 3'b111; mst_gnt_s = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      oh = 3'b001 << e;
      check_cnt++; if (gnt_s !== oh) $display("FAIL full_gnt%0d: got %b want %b", c, gnt_s, oh); else pass_cnt++;
      out_q.push_back(e);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_cnt++; if (mst_req_s !== 1'b0) $display("FAIL full_req_blocked: got %b want 0", mst_req_s); else pass_cnt++;
    check_cnt++; if (gnt_s !== 3'b000) $display("FAIL full_gnt_blocked: got %b want 000", gnt_s); else pass_cnt++;
    check_cnt++; if (busy_s !== 1'b1) $display("FAIL full_busy: got %b want 1", busy_s); else pass_cnt++;
    @(posedge clk); #1;
    mst_rvalid_s = 1'b1;
    @(negedge clk);
    e = out_q.pop_front();
    oh = 3'b001 << e;
    check_cnt++; if (rvalid_s !== oh) $display("FAIL full_pop_rvalid: got %b want %b", rvalid_s, oh); else pass_cnt++;
    check_cnt++; if (mst_req_s !== 1'b0) $display("FAIL full_pop_req: got %b want 0", mst_req_s); else pass_cnt++;
    @(posedge clk); #1;
    mst_rvalid_s = 1'b0;
    exp_q.push_back(2);
    @(negedge clk);
    e = exp_q.pop_front();
    oh = 3'b001 << e;
    check_cnt++; if (gnt_s !== oh) $display("FAIL full_next_gnt: got %b want %b", gnt_s, oh); else pass_cnt++;
    out_q.push_back(e);
    @(posedge clk); #1;
    req_s = '0; mst_gnt_s = 1'b0;
    for (int c = 0; c < 4 && out_q.size() != 0; c++) begin
      mst_rvalid_s = 1'b1;
      @(negedge clk);
      e = out_q.pop_front();
      oh = 3'b001 << e;
      check_cnt++; if (rvalid_s !== oh) $display("FAIL full_drain_rvalid%0d: got %b want %b", c, rvalid_s, oh); else pass_cnt++;
      @(posedge clk); #1;
    end
    mst_rvalid_s = 1'b0;
    @(negedge clk);
    check_cnt++; if (busy_s !== 1'b0) $display("FAIL full_idle_busy: got %b want 0", busy_s); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_resp_order();
    int e;
    logic [2:0] oh;
    logic [2:0] req_seq [3];
    req_seq = '{3'b100, 3'b001, 3'b010};
    apply_reset();
    weight = {4'd1, 4'd1, 4'd1};
    exp_q.push_back(2);
    exp_q.push_back(0);
    exp_q.push_back(1);
    for (int c = 0; c < 3; c++) begin
      req = req_seq[c]; mst_gnt = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      oh = 3'b001 << e;
      check_cnt++; if (gnt !== oh) $display("FAIL order_gnt%0d: got %b want %b", c, gnt, oh); else pass_cnt++;
      out_q.push_back(e);
      @(posedge clk); #1;
    end
    req = '0; mst_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mst_rvalid = 1'b1;
      @(negedge clk);
      e = out_q.pop_front();
      oh = 3'b001 << e;
      check_cnt++; if (rvalid !== oh) $display("FAIL order_rvalid%0d: got %b want %b", c, rvalid, oh); else pass_cnt++;
      check_cnt++; if (rsp_idx !== 2'(e)) $display("FAIL order_idx%0d: got %0d want %0d", c, rsp_idx, e); else pass_cnt++;
      check_cnt++; if (busy !== 1'b1) $display("FAIL order_busy%0d: got %b want 1", c, busy); else pass_cnt++;
      @(posedge clk); #1;
    end
    mst_rvalid = 1'b0;
    @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL order_busy_fall: got %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_flush();
    int e;
    logic [2:0] oh;
    apply_reset();
    weight = {4'd1, 4'd1, 4'd1};
    exp_q.push_back(0);
    exp_q.push_back(1);
    for (int c = 0; c < 2; c++) begin
      req = 3'b111; mst_gnt = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      oh = 3'b001 << e;
      check_cnt++; if (gnt !== oh) $display("FAIL flush_gnt%0d: got %b want %b", c, gnt, oh); else pass_cnt++;
      @(posedge clk); #1;
    end
    req = '0; mst_gnt = 1'b0;
    @(negedge clk);
    check_cnt++; if (busy !== 1'b1) $display("FAIL flush_busy_before: got %b want 1", busy); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy_in_reset: got %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy_after: got %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    mst_rvalid = 1'b1;
    @(negedge clk);
    check_cnt++; if (rvalid !== 3'b000) $display("FAIL flush_stray_rvalid: got %b want 000", rvalid); else pass_cnt++;
    check_cnt++; if (rsp_idx !== 2'd0) $display("FAIL flush_stray_idx: got %0d want 0", rsp_idx); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL flush_stray_busy: got %b want 0", busy); else pass_cnt++;
    @(posedge clk); #1;
    mst_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; mst_gnt = 1'b0; mst_rvalid = 1'b0;
    req_s = '0; mst_gnt_s = 1'b0; mst_rvalid_s = 1'b0;
    weight = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_wrr_order("rr_equal",  {4'd1, 4'd1, 4'd1}, '{0, 1, 2, 0, 1, 2, 0, 1});
    test_wrr_order("wrr_311",   {4'd1, 4'd1, 4'd3}, '{0, 0, 0, 1, 2, 0, 0, 0});
    test_wrr_order("wrr_zero",  {4'd1, 4'd2, 4'd0}, '{0, 1, 1, 2, 0, 1, 1, 2});
    test_lock_hold();
    test_fifo_full();
    test_resp_order();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
`default_nettype wire
